sram_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares one single-port SRAM macro between NB_REQ bus-side requesters.
- Sits between requester ports (bus slave front-ends, DMA) and the SRAM macro pins.
- Grants one requester at a time, drives chip-select/write-enable/address/data for one command cycle, waits WAIT_STATE cycles, then returns read data with a one-cycle completion pulse.

---
 rtl/sram_arbiter_if.sv | 34 +++
 rtl/sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Requester-side bus of the SRAM arbiter. It bundles every requester's
// request vectors with the arbiter's response signals.
//   master : requester side. Drives req_valid/req_write/req_addr/req_wdata
//            and observes req_ready/rdata/grant/busy.
//   slave  : arbiter side, with the opposite directions.
// Addresses and write data are packed: requester i occupies
// [i*ADDR_WIDTH +: ADDR_WIDTH] and [i*DATA_WIDTH +: DATA_WIDTH].
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [NB_REQ-1:0]            req_valid;
  logic [NB_REQ-1:0]            req_write;
  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NB_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NB_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]        rdata;
  logic [NB_REQ-1:0]            grant;
  logic                         busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rdata, grant, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rdata, grant, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Round-robin arbiter and access sequencer that shares one single-port SRAM
// macro between NB_REQ requesters. Each access runs through four phases:
// a grant cycle, one command cycle on the SRAM pins, WAIT_STATE access
// cycles, and a done cycle. The done cycle produces a one-hot req_ready
// pulse.
// Ports:
//   abus_clk    : clock
//   abus_rstb   : synchronous, active-low reset
//   bus         : requester bus (sram_arbiter_if.slave), which carries
//                 requests, req_ready, rdata, grant and busy
//   sram_cs/we  : SRAM chip select / write enable
//   sram_addr   : SRAM word address (holds between accesses)
//   sram_wdata  : SRAM write data (holds between accesses)
//   sram_rdata  : SRAM read data
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_STATE = 2
) (
  input  logic                  abus_clk,
  input  logic                  abus_rstb,
  sram_arbiter_if.slave         bus,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_DONE} state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      ptr, ptr_d;
  logic [IDX_W-1:0]      gnt_idx, gnt_idx_d;
  logic                  write_flag, write_flag_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [NB_REQ-1:0]     grant_d, ready_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  cs_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand_idx;
  int                    cand;

  assign bus.busy = (state != S_IDLE);

  // Round-robin search. The scan starts just after the last served
  // requester and wraps, so the previous owner has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NB_REQ; off++) begin
      cand     = (int'(ptr) + off) % NB_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and output logic. Every register holds its value by default.
  // Each state lists the updates that take effect on the edge that leaves
  // it.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    gnt_idx_d    = gnt_idx;
    write_flag_d = write_flag;
    cnt_d        = cnt;
    grant_d      = bus.grant;
    ready_d      = '0;
    rdata_d      = bus.rdata;
    cs_d         = sram_cs;
    we_d         = sram_we;
    addr_d       = sram_addr;
    wdata_d      = sram_wdata;

    case (state)
      S_IDLE: begin
        // Address, data and direction are latched here, so a requester
        // that changes them after the grant does not disturb the access.
        if (win_found) begin
          grant_d   = '0;
          gnt_idx_d = win_idx;
          cs_d      = 1'b1;
          state_d   = S_CMD;
          for (int i = 0; i < NB_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
              grant_d[i]   = 1'b1;
              addr_d       = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d      = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              we_d         = bus.req_write[i];
              write_flag_d = bus.req_write[i];
            end
          end
        end
      end

      S_CMD: begin
        cs_d = 1'b0;
        we_d = 1'b0;
        if (WAIT_STATE > 0) begin
          cnt_d   = CNT_W'(WAIT_STATE);
          state_d = S_WAIT;
        end else begin
          if (!write_flag) rdata_d = sram_rdata;
          state_d = S_DONE;
        end
      end

      S_WAIT: begin
        // The counter starts at WAIT_STATE. Leaving at 1 therefore gives
        // exactly WAIT_STATE cycles in this state.
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (!write_flag) rdata_d = sram_rdata;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        ready_d = bus.grant;
        ptr_d   = gnt_idx;
        grant_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register. A reset aborts any access in flight without a
  // req_ready pulse. It also rearms the pointer so requester 0 wins first.
  always_ff @(posedge abus_clk) begin
    if (!abus_rstb) begin
      state         <= S_IDLE;
      ptr           <= IDX_W'(NB_REQ - 1);
      gnt_idx       <= '0;
      write_flag    <= 1'b0;
      cnt           <= '0;
      bus.grant     <= '0;
      bus.req_ready <= '0;
      bus.rdata     <= '0;
      sram_cs       <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      gnt_idx       <= gnt_idx_d;
      write_flag    <= write_flag_d;
      cnt           <= cnt_d;
      bus.grant     <= grant_d;
      bus.req_ready <= ready_d;
      bus.rdata     <= rdata_d;
      sram_cs       <= cs_d;
      sram_we       <= we_d;
      sram_addr     <= addr_d;
      sram_wdata    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter. It drives two instances from one clock:
// dut_a uses WAIT_STATE=2 and dut_z uses WAIT_STATE=0. Each instance has an
// SRAM model with asynchronous reads and clocked writes. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int NB = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstb;

  always #5 clk = ~clk;

  sram_arbiter_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  sram_arbiter_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_z ();

  logic          cs_a, we_a, cs_z, we_z;
  logic [AW-1:0] addr_a, addr_z;
  logic [DW-1:0] wdata_a, wdata_z, srd_a, srd_z;

  sram_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATE(2)) dut_a (
    .abus_clk   (clk),
    .abus_rstb  (rstb),
    .bus        (bus_a),
    .sram_cs    (cs_a),
    .sram_we    (we_a),
    .sram_addr  (addr_a),
    .sram_wdata (wdata_a),
    .sram_rdata (srd_a)
  );

  sram_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATE(0)) dut_z (
    .abus_clk   (clk),
    .abus_rstb  (rstb),
    .bus        (bus_z),
    .sram_cs    (cs_z),
    .sram_we    (we_z),
    .sram_addr  (addr_z),
    .sram_wdata (wdata_z),
    .sram_rdata (srd_z)
  );

  // SRAM models. The preload port lets the bench seed known words.
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_z [0:1023];
  logic          pl_en_a, pl_en_z;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  assign srd_a = mem_a[addr_a];
  assign srd_z = mem_z[addr_z];

  always @(posedge clk) begin
    if (pl_en_a) mem_a[pl_addr] <= pl_data;
    else if (cs_a && we_a) mem_a[addr_a] <= wdata_a;
    if (pl_en_z) mem_z[pl_addr] <= pl_data;
    else if (cs_z && we_z) mem_z[addr_z] <= wdata_z;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic preload(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    if (sel) pl_en_z = 1'b1;
    else     pl_en_a = 1'b1;
    tick();
    pl_en_a = 1'b0;
    pl_en_z = 1'b0;
  endtask

  task automatic wait_ready_a(input logic [NB-1:0] exp, input int budget);
    int n = 0;
    while (bus_a.req_ready == '0 && n < budget) begin
      tick();
      n++;
    end
    check("ready_wait", bus_a.req_ready, exp);
  endtask

  logic [NB-1:0] exp_g;

  initial begin
    rstb    = 1'b0;
    pl_en_a = 1'b0;
    pl_en_z = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    bus_a.req_valid = 2'b11;
    bus_a.req_write = 2'b00;
    bus_a.req_addr  = {10'h000, 10'h012};
    bus_a.req_wdata = '0;
    bus_z.req_valid = 2'b00;
    bus_z.req_write = 2'b00;
    bus_z.req_addr  = {10'h000, 10'h020};
    bus_z.req_wdata = '0;

    // Reset with both requests held
    tick();
    preload(1'b0, 10'h012, 32'hDEADBEEF);
    preload(1'b1, 10'h020, 32'h12345678);
    tick();
    check("rst_grant", bus_a.grant, 2'b00);
    check("rst_ready", bus_a.req_ready, 2'b00);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_cs", cs_a, 1'b0);
    check("rst_we", we_a, 1'b0);
    check("rst_addr", addr_a, 10'h000);
    check("rst_wdata", wdata_a, 32'h0);
    check("rst_rdata", bus_a.rdata, 32'h0);

    // Release: requester 0 wins and reads 0x012
    rstb = 1'b1;
    tick();
    check("rd_grant", bus_a.grant, 2'b01);
    check("rd_cs_on", cs_a, 1'b1);
    check("rd_we", we_a, 1'b0);
    check("rd_addr", addr_a, 10'h012);
    check("rd_busy", bus_a.busy, 1'b1);
    bus_a.req_valid = 2'b01;
    tick();
    check("rd_cs_off", cs_a, 1'b0);
    check("rd_grant_hold", bus_a.grant, 2'b01);
    check("rd_ready_early1", bus_a.req_ready, 2'b00);
    tick();
    check("rd_ready_early2", bus_a.req_ready, 2'b00);
    tick();
    check("rd_ready_early3", bus_a.req_ready, 2'b00);
    check("rd_rdata", bus_a.rdata, 32'hDEADBEEF);
    check("rd_grant_done", bus_a.grant, 2'b01);
    tick();
    check("rd_ready", bus_a.req_ready, 2'b01);
    check("rd_grant_clr", bus_a.grant, 2'b00);
    check("rd_idle", bus_a.busy, 1'b0);
    bus_a.req_valid = 2'b00;

    // Continuous writes from both requesters alternate grants
    bus_a.req_write = 2'b11;
    bus_a.req_addr  = {10'h101, 10'h100};
    bus_a.req_wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
    bus_a.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      check("alt_grant", bus_a.grant, exp_g);
      check("alt_we_on", we_a, 1'b1);
      tick();
      check("alt_we_off", we_a, 1'b0);
      tick();
      tick();
      tick();
      check("alt_ready", bus_a.req_ready, exp_g);
    end
    bus_a.req_valid = 2'b00;
    check("alt_mem0", mem_a[10'h100], 32'hA0A0A0A0);
    check("alt_mem1", mem_a[10'h101], 32'hB1B1B1B1);
    check("alt_rdata_keep", bus_a.rdata, 32'hDEADBEEF);

    // Requester 1 writes 0x3FF, then requester 0 reads it back
    bus_a.req_write = 2'b10;
    bus_a.req_addr  = {10'h3FF, 10'h000};
    bus_a.req_wdata = {32'h55AA55AA, 32'h0};
    bus_a.req_valid = 2'b10;
    tick();
    check("wr_grant", bus_a.grant, 2'b10);
    check("wr_we_on", we_a, 1'b1);
    check("wr_addr", addr_a, 10'h3FF);
    check("wr_wdata", wdata_a, 32'h55AA55AA);
    bus_a.req_addr = {10'h000, 10'h000};
    tick();
    check("wr_we_off", we_a, 1'b0);
    check("wr_addr_latched", addr_a, 10'h3FF);
    tick();
    tick();
    tick();
    check("wr_ready", bus_a.req_ready, 2'b10);
    check("wr_rdata_keep", bus_a.rdata, 32'hDEADBEEF);
    bus_a.req_valid = 2'b00;
    check("wr_mem", mem_a[10'h3FF], 32'h55AA55AA);
    bus_a.req_write = 2'b00;
    bus_a.req_addr  = {10'h000, 10'h3FF};
    bus_a.req_valid = 2'b01;
    tick();
    check("rb_grant", bus_a.grant, 2'b01);
    check("rb_we", we_a, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("rb_ready", bus_a.req_ready, 2'b01);
    check("rb_rdata", bus_a.rdata, 32'h55AA55AA);
    bus_a.req_valid = 2'b00;
    tick();
    check("idle_addr_hold", addr_a, 10'h3FF);

    // Zero wait states: the access completes two edges after the grant
    bus_z.req_valid = 2'b01;
    tick();
    check("z_grant", bus_z.grant, 2'b01);
    check("z_cs_on", cs_z, 1'b1);
    tick();
    check("z_cs_off", cs_z, 1'b0);
    check("z_ready_early", bus_z.req_ready, 2'b00);
    check("z_rdata", bus_z.rdata, 32'h12345678);
    check("z_grant_done", bus_z.grant, 2'b01);
    tick();
    check("z_ready", bus_z.req_ready, 2'b01);
    check("z_grant_clr", bus_z.grant, 2'b00);
    check("z_idle", bus_z.busy, 1'b0);
    bus_z.req_valid = 2'b00;

    // Reset during the wait phase aborts the access
    bus_a.req_addr  = {10'h000, 10'h012};
    bus_a.req_valid = 2'b01;
    tick();
    check("ab_grant", bus_a.grant, 2'b01);
    tick();
    rstb = 1'b0;
    bus_a.req_valid = 2'b11;
    tick();
    check("ab_grant_clr", bus_a.grant, 2'b00);
    check("ab_ready", bus_a.req_ready, 2'b00);
    check("ab_cs", cs_a, 1'b0);
    check("ab_busy", bus_a.busy, 1'b0);
    check("ab_addr", addr_a, 10'h000);
    check("ab_rdata", bus_a.rdata, 32'h0);
    tick();
    check("ab_ready_hold", bus_a.req_ready, 2'b00);
    rstb = 1'b1;
    tick();
    check("ab_ptr_reset", bus_a.grant, 2'b01);
    bus_a.req_valid = 2'b01;
    wait_ready_a(2'b01, 10);
    check("ab_rdata_new", bus_a.rdata, 32'hDEADBEEF);
    bus_a.req_valid = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
